// File: rtl/pc_pipe_if.sv
// Bus bundle for the program-counter unit: redirect/stall controls in,
// fetch PC and delayed-PC taps out.
interface pc_pipe_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                    stall_i;
  logic                    incr_pc_i;
  logic                    load_arith_i;
  logic [XLEN-1:0]         arith_out_i;
  logic                    trap_i;
  logic [XLEN-1:0]         trap_vec_i;
  logic [XLEN-1:0]         pc_o;
  logic                    pc_vld_o;
  logic [DEPTH*XLEN-1:0]   pc_dly_o;
  logic [DEPTH-1:0]        pc_dly_vld_o;
  logic                    misalign_o;

  modport master (
    output stall_i, incr_pc_i, load_arith_i, arith_out_i, trap_i, trap_vec_i,
    input  pc_o, pc_vld_o, pc_dly_o, pc_dly_vld_o, misalign_o
  );

  modport slave (
    input  stall_i, incr_pc_i, load_arith_i, arith_out_i, trap_i, trap_vec_i,
    output pc_o, pc_vld_o, pc_dly_o, pc_dly_vld_o, misalign_o
  );
endinterface

// File: rtl/pc_pipe.sv
// Fetch program counter plus a DEPTH-stage pipeline of delayed PCs with valid
// bits; handles stall, arithmetic redirect with partial kill, and trap flush.
module pc_pipe #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 2,
  parameter int              KILL_DEPTH  = 1,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = '0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  pc_pipe_if.slave bus
);
  localparam int              A          = (INSTR_BYTES == 4) ? 2 : 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pc_pipe: DEPTH must be >= 1");
  end
  if (KILL_DEPTH < 1 || KILL_DEPTH > DEPTH) begin : g_bad_kill
    $error("pc_pipe: KILL_DEPTH must be in 1..DEPTH");
  end
  if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_ib
    $error("pc_pipe: INSTR_BYTES must be 2 or 4");
  end

  logic [XLEN-1:0]             r_pc;
  logic                        r_pc_vld;
  logic                        r_misalign;
  logic [XLEN-1:0]             w_pc_next;
  logic                        w_load;
  logic [DEPTH-1:0][XLEN-1:0]  w_dly_pc;
  logic [DEPTH-1:0]            w_dly_vld;

  // A load only takes effect when neither a trap nor a stall blocks it.
  assign w_load = bus.load_arith_i & ~bus.stall_i & ~bus.trap_i;

  always_comb begin
    w_pc_next = r_pc;
    if (bus.trap_i) begin
      w_pc_next = bus.trap_vec_i & ALIGN_MASK;
    end else if (bus.stall_i) begin
      w_pc_next = r_pc;
    end else if (bus.load_arith_i) begin
      w_pc_next = bus.arith_out_i & ALIGN_MASK;
    end else if (bus.incr_pc_i) begin
      w_pc_next = r_pc + STEP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= RESET_VEC;
      r_pc_vld   <= 1'b1;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_pc_vld   <= 1'b1;
      r_misalign <= w_load & (|bus.arith_out_i[A-1:0]);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    localparam bit KILL = (gi < KILL_DEPTH);
    logic [XLEN-1:0] r_stage_pc;
    logic            r_stage_vld;
    logic [XLEN-1:0] w_src_pc;
    logic            w_src_vld;

    // Stage 1 samples the fetch PC; older stages sample their younger neighbour.
    if (gi == 0) begin : g_head
      assign w_src_pc  = r_pc;
      assign w_src_vld = 1'b1;
    end else begin : g_tail
      assign w_src_pc  = w_dly_pc[gi-1];
      assign w_src_vld = w_dly_vld[gi-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_stage_pc  <= '0;
        r_stage_vld <= 1'b0;
      end else if (bus.trap_i) begin
        r_stage_vld <= 1'b0;
      end else if (!bus.stall_i) begin
        r_stage_pc  <= w_src_pc;
        r_stage_vld <= w_src_vld & ~(bus.load_arith_i & KILL);
      end
    end

    assign w_dly_pc[gi]  = r_stage_pc;
    assign w_dly_vld[gi] = r_stage_vld;
  end

  assign bus.pc_o         = r_pc;
  assign bus.pc_vld_o     = r_pc_vld;
  assign bus.pc_dly_o     = w_dly_pc;
  assign bus.pc_dly_vld_o = w_dly_vld;
  assign bus.misalign_o   = r_misalign;
endmodule

// File: tb/tb_pc_pipe.sv
// Scoreboard bench for pc_pipe: two configurations driven in lockstep and
// checked against a high-level reference model, one line per transaction.
module tb_pc_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_pipe_if #(.XLEN(32), .DEPTH(2)) if0 ();
  pc_pipe_if #(.XLEN(32), .DEPTH(3)) if1 ();

  pc_pipe #(.XLEN(32), .DEPTH(2), .KILL_DEPTH(1), .INSTR_BYTES(4), .RESET_VEC(32'h0))
    u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  pc_pipe #(.XLEN(32), .DEPTH(3), .KILL_DEPTH(2), .INSTR_BYTES(2), .RESET_VEC(32'h1000))
    u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic [95:0] dly;
    logic [2:0]  dvld;
    logic        mis;
  } obs_t;

  int unsigned       dep [2] = '{2, 3};
  int unsigned       kd  [2] = '{1, 2};
  int unsigned       ib  [2] = '{4, 2};
  logic [31:0]       rv  [2] = '{32'h0, 32'h1000};

  // Reference state: fetch PC plus an ordered list of (pc, valid) history entries.
  logic [31:0] m_pc  [2];
  logic [31:0] m_spc [2][3];
  logic        m_sv  [2][3];
  logic        m_mis [2];

  obs_t  q0 [$];
  obs_t  q1 [$];
  string qn [$];
  int    checks = 0;
  int    errors = 0;
  int    txn    = 0;

  function automatic obs_t model_obs(int c);
    obs_t o;
    o = '0;
    o.pc  = m_pc[c];
    o.vld = 1'b1;
    o.mis = m_mis[c];
    for (int k = 0; k < int'(dep[c]); k++) begin
      o.dly[k*32 +: 32] = m_spc[c][k];
      o.dvld[k]         = m_sv[c][k];
    end
    return o;
  endfunction

  function automatic obs_t dut_obs(int c);
    obs_t o;
    o = '0;
    if (c == 0) begin
      o.pc   = if0.pc_o;
      o.vld  = if0.pc_vld_o;
      o.dly  = {32'h0, if0.pc_dly_o};
      o.dvld = {1'b0, if0.pc_dly_vld_o};
      o.mis  = if0.misalign_o;
    end else begin
      o.pc   = if1.pc_o;
      o.vld  = if1.pc_vld_o;
      o.dly  = if1.pc_dly_o;
      o.dvld = if1.pc_dly_vld_o;
      o.mis  = if1.misalign_o;
    end
    return o;
  endfunction

  function automatic void check(int c, obs_t e, string tag);
    obs_t a;
    a = dut_obs(c);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cfg%0d: got pc=%h vld=%b dly=%h dvld=%b mis=%b, expected pc=%h vld=%b dly=%h dvld=%b mis=%b",
               tag, c, a.pc, a.vld, a.dly, a.dvld, a.mis, e.pc, e.vld, e.dly, e.dvld, e.mis);
    end
  endfunction

  function automatic void model_step(int c, logic r, logic s, logic inc, logic ld,
                                     logic [31:0] ao, logic tr, logic [31:0] tv);
    logic [31:0] old_pc;
    logic [32:0] sum;
    if (r) begin
      m_pc[c]  = rv[c];
      m_mis[c] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_spc[c][k] = '0;
        m_sv[c][k]  = 1'b0;
      end
    end else begin
      m_mis[c] = ld && !s && !tr && ((ao % ib[c]) != 0);
      if (tr) begin
        m_pc[c] = tv - (tv % ib[c]);
        for (int k = 0; k < 3; k++) m_sv[c][k] = 1'b0;
      end else if (!s) begin
        old_pc = m_pc[c];
        for (int k = int'(dep[c]) - 1; k >= 1; k--) begin
          m_spc[c][k] = m_spc[c][k-1];
          m_sv[c][k]  = m_sv[c][k-1] && !(ld && (k + 1) <= int'(kd[c]));
        end
        m_spc[c][0] = old_pc;
        m_sv[c][0]  = !ld;
        if (ld) begin
          m_pc[c] = ao - (ao % ib[c]);
        end else if (inc) begin
          sum     = {1'b0, old_pc} + 33'(ib[c]);
          m_pc[c] = sum[31:0];
        end
      end
    end
  endfunction

  task automatic step(input string tag, input logic r, input logic s, input logic inc,
                      input logic ld, input logic [31:0] ao, input logic tr,
                      input logic [31:0] tv);
    @(negedge clk);
    rst = r;
    if0.stall_i = s; if0.incr_pc_i = inc; if0.load_arith_i = ld;
    if0.arith_out_i = ao; if0.trap_i = tr; if0.trap_vec_i = tv;
    if1.stall_i = s; if1.incr_pc_i = inc; if1.load_arith_i = ld;
    if1.arith_out_i = ao; if1.trap_i = tr; if1.trap_vec_i = tv;
    for (int c = 0; c < 2; c++) model_step(c, r, s, inc, ld, ao, tr, tv);
    q0.push_back(model_obs(0));
    q1.push_back(model_obs(1));
    qn.push_back(tag);
  endtask

  // Monitor: every cycle the DUTs present a new state; compare against queued expectation.
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0 && qn.size() > 0) begin
        t = qn.pop_front();
        e = q0.pop_front();
        check(0, e, t);
        e = q1.pop_front();
        check(1, e, t);
        txn++;
        $display("txn %0d %s cfg0 pc=%h dvld=%b mis=%b cfg1 pc=%h dvld=%b mis=%b",
                 txn, t, if0.pc_o, if0.pc_dly_vld_o, if0.misalign_o,
                 if1.pc_o, if1.pc_dly_vld_o, if1.misalign_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, s, inc, ld, tr;
    logic [31:0] ao, tv;
    rst = 1'b1;
    if0.stall_i = 0; if0.incr_pc_i = 0; if0.load_arith_i = 0;
    if0.arith_out_i = 0; if0.trap_i = 0; if0.trap_vec_i = 0;
    if1.stall_i = 0; if1.incr_pc_i = 0; if1.load_arith_i = 0;
    if1.arith_out_i = 0; if1.trap_i = 0; if1.trap_vec_i = 0;
    for (int c = 0; c < 2; c++) model_step(c, 1'b1, 0, 0, 0, 0, 0, 0);

    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    repeat (4) step("incr", 0, 0, 1, 0, 0, 0, 0);
    step("ld100", 0, 0, 0, 1, 32'h100, 0, 0);
    step("ld200", 0, 0, 0, 1, 32'h200, 0, 0);
    step("ld_vs_incr", 0, 0, 1, 1, 32'h240, 0, 0);
    step("incr", 0, 0, 1, 0, 0, 0, 0);
    repeat (3) step("stall", 0, 1, 1, 1, 32'h400, 0, 0);
    repeat (2) step("resume", 0, 0, 1, 0, 0, 0, 0);
    step("trap_stall", 0, 1, 0, 1, 32'h123, 1, 32'h80);
    step("incr", 0, 0, 1, 0, 0, 0, 0);
    step("trap_odd", 0, 0, 1, 0, 0, 1, 32'h87);
    step("ld302", 0, 0, 0, 1, 32'h302, 0, 0);
    repeat (2) step("after_mis", 0, 0, 1, 0, 0, 0, 0);
    step("ld_top", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    repeat (2) step("wrap", 0, 0, 1, 0, 0, 0, 0);
    step("incr", 0, 0, 1, 0, 0, 0, 0);
    step("async_rst", 1, 0, 1, 0, 0, 0, 0);
    #1;
    check(0, model_obs(0), "async_rst_now");
    check(1, model_obs(1), "async_rst_now");
    step("reset", 1, 0, 1, 0, 0, 0, 0);
    step("post_rst", 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 3) == 0);
      inc = $urandom_range(0, 1);
      ld  = ($urandom_range(0, 3) == 0);
      tr  = ($urandom_range(0, 15) == 0);
      ao  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tv  = $urandom;
      step("rand", r, s, inc, ld, ao, tr, tv);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_pipe.md
Name: pc_pipe

Overview:
- Parametrised program-counter unit: holds the fetch PC and a DEPTH-stage shift pipeline of delayed PCs, each stage with a valid bit.
- Supports stall, arithmetic redirect (branch/jump), trap redirect with full flush, configurable kill depth, and misaligned-target flagging.
- Sits between the fetch stage and the ALU/control path. Downstream stages read their own instruction's PC from the delay taps.

Parameters:
- XLEN, 32, PC and target width in bits.
- DEPTH, 2, number of delayed-PC stages (>=1).
- KILL_DEPTH, 1, number of youngest delay stages invalidated on an arithmetic redirect (1..DEPTH).
- INSTR_BYTES, 4, increment step and alignment in bytes (2 or 4).
- RESET_VEC, 32'h0, PC value after reset.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- stall_i  input  1  hold PC and all delay stages.
- incr_pc_i  input  1  advance PC by INSTR_BYTES.
- load_arith_i  input  1  redirect PC to arith_out_i.
- arith_out_i  input  XLEN  redirect target from ALU.
- trap_i  input  1  trap redirect to trap_vec_i; overrides stall.
- trap_vec_i  input  XLEN  trap handler address.
- pc_o  output  XLEN  current fetch PC (registered).
- pc_vld_o  output  1  pc_o holds a valid fetch address (registered).
- pc_dly_o  output  DEPTH*XLEN  delay stage k (1..DEPTH) at bits [k*XLEN-1:(k-1)*XLEN].
- pc_dly_vld_o  output  DEPTH  valid bit of stage k at bit k-1.
- misalign_o  output  1  one-cycle registered flag: last arith redirect target was misaligned.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: pc_o=RESET_VEC, pc_vld_o=1, all pc_dly_o=0, pc_dly_vld_o=0, misalign_o=0.
- Reset asserted mid-operation overrides everything immediately (asynchronous). First update occurs on the first clock edge after rst_i deasserts.
- Let A = log2(INSTR_BYTES).
- Next-PC priority, evaluated each rising edge:
  - trap_i: pc <= trap_vec_i with low A bits cleared.
  - else stall_i: pc holds.
  - else load_arith_i: pc <= arith_out_i with low A bits cleared.
  - else incr_pc_i: pc <= pc + INSTR_BYTES, modulo 2^XLEN (0xFFFFFFFC+4 -> 0 at XLEN=32).
  - else pc holds.
- pc_vld_o: 1 after reset and after any load. It is never cleared (reserved for future fetch-fault use); it is kept for interface stability.
- Delay pipeline on trap_i, even when stall_i=1:
  - all stages keep their PC values;
  - all pc_dly_vld_o bits <= 0 (full flush).
- Delay pipeline on a non-stalled, non-trap cycle:
  - stage1 <= pc_o, vld1 <= ~load_arith_i;
  - stage k <= stage k-1, vld_k <= vld_{k-1} & ~(load_arith_i & k<=KILL_DEPTH) for k in 2..DEPTH.
  - The PC and valid values shift regardless of incr_pc_i; only the kill mask depends on load_arith_i.
- Delay pipeline on stall_i=1 without trap: every stage holds PC and valid bit unchanged. There is no internal feedback between stages.
- misalign_o: set to 1 for exactly the cycle after an accepted load_arith_i whose arith_out_i[A-1:0] != 0; otherwise 0.
  - Not set for traps.
  - Not set when the load is blocked by stall_i or trap_i.
- Simultaneous events:
  - trap_i with load_arith_i: trap wins, no misalign.
  - stall_i with load_arith_i: load ignored; the source must hold it until the stall drops.
  - load_arith_i with incr_pc_i: load wins.
- Outputs are driven only from registers; there are no combinational input-to-output paths.
- Elaboration error if DEPTH<1, KILL_DEPTH outside 1..DEPTH, or INSTR_BYTES not in {2,4}.

Test Plan:
- Reset then incr_pc_i=1 for 4 cycles, defaults -> pc_o 0,4,8,12,16. Stage1 lags one cycle, stage2 two cycles. pc_dly_vld_o becomes 2'b01 then 2'b11.
- At pc=0x100, load_arith_i=1 with arith_out_i=0x200 -> pc_o=0x200 next cycle. Stage1 vld=0 (kill), stage2 takes old stage1 with its valid bit. With KILL_DEPTH=2, stage2 vld=0 as well.
- stall_i=1 for 3 cycles with incr_pc_i=1 and load_arith_i=1 -> pc_o, all stages and all valid bits frozen. Resume: increment from the held value.
- trap_i=1 while stall_i=1, trap_vec_i=0x80 -> pc_o=0x80, pc_dly_vld_o=0 for all stages, misalign_o stays 0.
- load_arith_i with arith_out_i=0x302 -> pc_o=0x300 and misalign_o=1 for exactly one cycle. With INSTR_BYTES=2: pc_o=0x302, misalign_o=0.
- pc=0xFFFFFFFC with incr_pc_i=1 -> pc_o=0x0. Assert rst_i mid-stream between clock edges -> outputs return to reset values immediately.
